// File: rtl/fft_pkg.sv
// Shared constants, reader state and bit-reverse helper
// for the FFT bit-reversal feeder.
package fft_pkg;
  localparam int FFT_N     = 16;
  localparam int FFT_LOG2N = 4;
  localparam int FFT_WIDTH = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_t;

  function automatic logic [FFT_LOG2N-1:0] bitrev(
    input logic [FFT_LOG2N-1:0] a
  );
    logic [FFT_LOG2N-1:0] r;
    for (int i = 0; i < FFT_LOG2N; i++)
      r[i] = a[FFT_LOG2N-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_bitrev_bank.sv
// Simple dual-port ping-pong frame store, address {bank, addr}.
// Synchronous write, registered read.
module fft_bitrev_bank
  import fft_pkg::*;
#(
  parameter int DW = 2 * FFT_WIDTH,
  parameter int AW = FFT_LOG2N + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register doubles as the output data register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fft_bitrev_feeder.sv
// Natural-order to bit-reversed-order frame reorder for
// the SDF FFT input, double-buffered for gapless streaming.
module fft_bitrev_feeder
  import fft_pkg::*;
#(
  parameter int WIDTH = FFT_WIDTH,
  parameter int N     = FFT_N,
  parameter int LOG2N = FFT_LOG2N
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_en,
  input  logic signed [WIDTH-1:0] in_real,
  input  logic signed [WIDTH-1:0] in_imag,
  output logic                    out_en,
  output logic signed [WIDTH-1:0] out_real,
  output logic signed [WIDTH-1:0] out_imag,
  output logic                    out_start,
  output logic                    out_last,
  output logic [15:0]             frame_count
);
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  logic [LOG2N-1:0]   wptr;
  logic [LOG2N-1:0]   rcnt;
  logic               wbank;
  logic               rbank;
  logic [1:0]         full;
  logic [1:0]         set_full;
  logic [1:0]         clr_full;
  rd_state_t          state;
  logic               we;
  logic               rd;
  logic               at_last;
  logic [2*WIDTH-1:0] rdata;

  assign rd      = (state == BURST);
  assign at_last = rd && (rcnt == LAST);

  always_comb begin
    clr_full = '0;
    if (at_last) clr_full[rbank] = 1'b1;
  end

  // A bank released by the reader this edge is writable now.
  assign we = in_en && !(full[wbank] && !clr_full[wbank]);

  always_comb begin
    set_full = '0;
    if (we && wptr == LAST) set_full[wbank] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      wbank <= 1'b0;
      full  <= '0;
    end else begin
      full <= (full & ~clr_full) | set_full;
      if (we) begin
        wptr <= wptr + 1'b1;
        if (wptr == LAST) wbank <= ~wbank;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rbank <= 1'b0;
      rcnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (full[rbank]) begin
            state <= BURST;
            rcnt  <= '0;
          end
        end
        BURST: begin
          rcnt <= rcnt + 1'b1;
          if (at_last) begin
            rbank <= ~rbank;
            if (!full[~rbank]) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_en      <= 1'b0;
      out_start   <= 1'b0;
      out_last    <= 1'b0;
      frame_count <= '0;
    end else begin
      out_en      <= rd;
      out_start   <= rd && (rcnt == '0);
      out_last    <= at_last;
      frame_count <= frame_count + 16'(at_last);
    end
  end

  fft_bitrev_bank #(
    .DW (2 * WIDTH),
    .AW (LOG2N + 1)
  ) u_bank (
    .clock (clock),
    .reset (reset),
    .we    (we),
    .waddr ({wbank, wptr}),
    .wdata ({in_real, in_imag}),
    .re    (rd),
    .raddr ({rbank, bitrev(rcnt)}),
    .rdata (rdata)
  );

  assign out_real = rdata[2*WIDTH-1:WIDTH];
  assign out_imag = rdata[WIDTH-1:0];
endmodule

// File: tb/tb_fft_bitrev_feeder.sv
// Directed bench for fft_bitrev_feeder: reorder, latency,
// gaps, back-to-back frames and asynchronous reset.
module tb_fft_bitrev_feeder;
  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               in_en = 1'b0;
  logic signed [31:0] in_real = '0;
  logic signed [31:0] in_imag = '0;
  logic               out_en;
  logic signed [31:0] out_real;
  logic signed [31:0] out_imag;
  logic               out_start;
  logic               out_last;
  logic [15:0]        frame_count;

  fft_bitrev_feeder dut (
    .clock       (clock),
    .reset       (reset),
    .in_en       (in_en),
    .in_real     (in_real),
    .in_imag     (in_imag),
    .out_en      (out_en),
    .out_real    (out_real),
    .out_imag    (out_imag),
    .out_start   (out_start),
    .out_last    (out_last),
    .frame_count (frame_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic signed [31:0] re;
    logic signed [31:0] im;
    logic               st;
    logic               ls;
    int                 c;
  } obs_t;

  obs_t q[$];
  obs_t mon_o;
  int   cyc = 0;
  int   t_last = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   br[16] = '{0, 8, 4, 12, 2, 10, 6, 14,
                   1, 9, 5, 13, 3, 11, 7, 15};
  int   cosv[16] = '{32768, 30274, 23170, 12540,
                     0, -12540, -23170, -30274,
                     -32768, -30274, -23170, -12540,
                     0, 12540, 23170, 30274};

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset === 1'b1 && out_en === 1'b1) begin
      mon_o.re = out_real;
      mon_o.im = out_imag;
      mon_o.st = out_start;
      mon_o.ls = out_last;
      mon_o.c  = cyc;
      q.push_back(mon_o);
    end
  end

  task automatic send(input int r, input int i);
    @(posedge clock);
    #1;
    in_en   = 1'b1;
    in_real = r;
    in_imag = i;
    t_last  = cyc + 1;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clock);
      #1 in_en = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    in_en = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    q.delete();
  endtask

  task automatic wait_obs(input int n, input int budget);
    int k = 0;
    while (q.size() < n && k < budget) begin
      @(posedge clock);
      k++;
    end
    vectors++;
    if (q.size() < n) begin
      miscompares++;
      $display("FAIL wait_obs: got %0d samples, need %0d",
               q.size(), n);
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (out_en !== 1'b0 || out_start !== 1'b0 ||
        out_last !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: en=%b st=%b ls=%b want 000",
               out_en, out_start, out_last);
    end
    vectors++;
    if (out_real !== 32'sd0 || out_imag !== 32'sd0) begin
      miscompares++;
      $display("FAIL reset_data: re=%0d im=%0d want 0 0",
               out_real, out_imag);
    end
    vectors++;
    if (frame_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_fc: got %0d want 0", frame_count);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic test_single_frame();
    logic signed [31:0] er, ei;
    apply_reset();
    for (int n = 0; n < 16; n++) send(n, -n);
    idle(1);
    wait_obs(16, 60);
    idle(5);
    vectors++;
    if (q.size() != 16) begin
      miscompares++;
      $display("FAIL s1_count: got %0d want 16", q.size());
    end
    for (int k = 0; k < 16 && k < q.size(); k++) begin
      er = br[k];
      ei = -br[k];
      vectors++;
      if (q[k].re !== er || q[k].im !== ei) begin
        miscompares++;
        $display("FAIL s1_data[%0d]: got %0d,%0d want %0d,%0d",
                 k, q[k].re, q[k].im, er, ei);
      end
      vectors++;
      if (q[k].st !== (k == 0) || q[k].ls !== (k == 15)) begin
        miscompares++;
        $display("FAIL s1_flags[%0d]: st=%b ls=%b", k,
                 q[k].st, q[k].ls);
      end
      vectors++;
      if (q[k].c != q[0].c + k) begin
        miscompares++;
        $display("FAIL s1_contig[%0d]: cycle %0d want %0d",
                 k, q[k].c, q[0].c + k);
      end
    end
    if (q.size() > 0) begin
      vectors++;
      if (q[0].c != t_last + 2) begin
        miscompares++;
        $display("FAIL s1_latency: first at %0d want %0d",
                 q[0].c, t_last + 2);
      end
    end
    vectors++;
    if (frame_count !== 16'd1) begin
      miscompares++;
      $display("FAIL s1_fc: got %0d want 1", frame_count);
    end
  endtask

  task automatic test_cosine();
    logic signed [31:0] er;
    apply_reset();
    for (int n = 0; n < 16; n++) send(cosv[n], 0);
    idle(1);
    wait_obs(16, 60);
    idle(3);
    for (int k = 0; k < 16 && k < q.size(); k++) begin
      er = cosv[br[k]];
      vectors++;
      if (q[k].re !== er || q[k].im !== 32'sd0) begin
        miscompares++;
        $display("FAIL cos_data[%0d]: got %0d,%0d want %0d,0",
                 k, q[k].re, q[k].im, er);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic signed [31:0] er, ei;
    int t0 = 0;
    apply_reset();
    for (int f = 0; f < 4; f++)
      for (int n = 0; n < 16; n++) begin
        send(100 * f + n, -(100 * f + n));
        if (f == 0 && n == 15) t0 = t_last;
      end
    idle(1);
    wait_obs(64, 150);
    idle(5);
    vectors++;
    if (q.size() != 64) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d want 64", q.size());
    end
    for (int i = 0; i < 64 && i < q.size(); i++) begin
      er = 100 * (i / 16) + br[i % 16];
      ei = -er;
      vectors++;
      if (q[i].re !== er || q[i].im !== ei) begin
        miscompares++;
        $display("FAIL b2b_data[%0d]: got %0d,%0d want %0d,%0d",
                 i, q[i].re, q[i].im, er, ei);
      end
      vectors++;
      if (q[i].st !== (i % 16 == 0) ||
          q[i].ls !== (i % 16 == 15)) begin
        miscompares++;
        $display("FAIL b2b_flags[%0d]: st=%b ls=%b", i,
                 q[i].st, q[i].ls);
      end
      vectors++;
      if (q[i].c != q[0].c + i) begin
        miscompares++;
        $display("FAIL b2b_contig[%0d]: cycle %0d want %0d",
                 i, q[i].c, q[0].c + i);
      end
    end
    if (q.size() > 0) begin
      vectors++;
      if (q[0].c != t0 + 2) begin
        miscompares++;
        $display("FAIL b2b_latency: first at %0d want %0d",
                 q[0].c, t0 + 2);
      end
    end
    vectors++;
    if (frame_count !== 16'd4) begin
      miscompares++;
      $display("FAIL b2b_fc: got %0d want 4", frame_count);
    end
  endtask

  task automatic test_gapped();
    logic signed [31:0] er;
    apply_reset();
    for (int n = 0; n < 16; n++) begin
      send(n, -n);
      idle(1);
    end
    wait_obs(16, 60);
    idle(5);
    vectors++;
    if (q.size() != 16) begin
      miscompares++;
      $display("FAIL gap_count: got %0d want 16", q.size());
    end
    for (int k = 0; k < 16 && k < q.size(); k++) begin
      er = br[k];
      vectors++;
      if (q[k].re !== er || q[k].im !== -er ||
          q[k].c != q[0].c + k) begin
        miscompares++;
        $display("FAIL gap_data[%0d]: got %0d,%0d @%0d want %0d",
                 k, q[k].re, q[k].im, q[k].c, er);
      end
    end
    if (q.size() > 0) begin
      vectors++;
      if (q[0].c != t_last + 2) begin
        miscompares++;
        $display("FAIL gap_latency: first at %0d want %0d",
                 q[0].c, t_last + 2);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic signed [31:0] er;
    apply_reset();
    for (int n = 0; n < 16; n++) send(n, n);
    for (int n = 0; n < 7; n++) send(100 + n, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    in_en = 1'b0;
    #1;
    vectors++;
    if (out_en !== 1'b0 || out_start !== 1'b0 ||
        out_last !== 1'b0 || out_real !== 32'sd0) begin
      miscompares++;
      $display("FAIL mid_async: en=%b st=%b ls=%b re=%0d",
               out_en, out_start, out_last, out_real);
    end
    vectors++;
    if (q.size() != 5) begin
      miscompares++;
      $display("FAIL mid_partial: got %0d samples want 5",
               q.size());
    end
    for (int k = 0; k < q.size() && k < 16; k++) begin
      er = br[k];
      vectors++;
      if (q[k].re !== er) begin
        miscompares++;
        $display("FAIL mid_data[%0d]: got %0d want %0d",
                 k, q[k].re, er);
      end
    end
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    q.delete();
    idle(30);
    vectors++;
    if (q.size() != 0 || frame_count !== 16'd0) begin
      miscompares++;
      $display("FAIL mid_quiet: %0d samples fc=%0d want 0 0",
               q.size(), frame_count);
    end
    for (int n = 0; n < 16; n++) send(50 + n, 0);
    idle(1);
    wait_obs(16, 60);
    idle(3);
    for (int k = 0; k < 16 && k < q.size(); k++) begin
      er = 50 + br[k];
      vectors++;
      if (q[k].re !== er) begin
        miscompares++;
        $display("FAIL mid_fresh[%0d]: got %0d want %0d",
                 k, q[k].re, er);
      end
    end
    vectors++;
    if (frame_count !== 16'd1) begin
      miscompares++;
      $display("FAIL mid_fc: got %0d want 1", frame_count);
    end
  endtask

  task automatic test_stall();
    logic signed [31:0] er;
    apply_reset();
    for (int n = 0; n < 15; n++) send(200 + n, n);
    idle(40);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL stall_early: got %0d samples want 0",
               q.size());
    end
    send(215, 15);
    idle(1);
    wait_obs(16, 60);
    idle(3);
    for (int k = 0; k < 16 && k < q.size(); k++) begin
      er = 200 + br[k];
      vectors++;
      if (q[k].re !== er || q[k].im !== 32'(br[k])) begin
        miscompares++;
        $display("FAIL stall_data[%0d]: got %0d,%0d want %0d,%0d",
                 k, q[k].re, q[k].im, er, br[k]);
      end
    end
    if (q.size() > 0) begin
      vectors++;
      if (q[0].c != t_last + 2) begin
        miscompares++;
        $display("FAIL stall_latency: first at %0d want %0d",
                 q[0].c, t_last + 2);
      end
    end
    vectors++;
    if (frame_count !== 16'd1) begin
      miscompares++;
      $display("FAIL stall_fc: got %0d want 1", frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_cosine();
    test_back_to_back();
    test_gapped();
    test_reset_mid();
    test_stall();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fft_bitrev_feeder.md
Name: fft_bitrev_feeder

Overview:
Streaming reorder front-end for the radix-2 SDF FFT (fft_16_top). It accepts complex samples in natural time order and re-emits each N-sample frame in bit-reversed order. The output is a contiguous N-cycle burst, which is the form fft_16_top consumes on input_en/input_real/input_imag. Frames are double-buffered in ping-pong banks, so back-to-back frames stream at one sample per clock with no gaps.

Parameters:
WIDTH, 32, bit width of each signed real/imag component
N, 16, frame length (power of two, ≥4)
LOG2N, 4, log2(N); address and counter width

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
in_en  in  1  input sample valid this cycle
in_real  in  WIDTH  signed real part, natural order
in_imag  in  WIDTH  signed imag part, natural order
out_en  out  1  output sample valid; drives fft_16_top.input_en
out_real  out  WIDTH  signed real part, bit-reversed order
out_imag  out  WIDTH  signed imag part, bit-reversed order
out_start  out  1  pulses with the first sample of a frame
out_last  out  1  pulses with the last sample of a frame
frame_count  out  16  completed output frames, wraps at 2^16

Behaviour:
- Reset (reset=0, asynchronous): out_en=0, out_start=0, out_last=0, out_real=0, out_imag=0, frame_count=0. Write pointer is 0, write bank is 0, both bank-full flags are clear, reader is IDLE. Bank RAM contents are not reset and are don't-care.
- Write side:
  - On each edge with in_en=1, store {in_real,in_imag} at address wptr of the write bank, then increment wptr.
  - When wptr wraps from N-1 to 0 on that edge: set full[wbank] and toggle wbank.
  - in_en gaps hold wptr. A partial frame resumes where it stopped and is never emitted early.
- Overrun rule: a write into a bank whose full flag is still set must not corrupt data being read.
  - At one sample per clock this cannot occur, because the reader releases a bank on the same edge the writer could first reach it.
  - The write enable is still qualified with !full[wbank]. A blocked sample is dropped.
- Read FSM:
  - IDLE: if full[rbank] is set, go to BURST with rcnt=0.
  - BURST: each cycle read address bitrev(rcnt) from rbank; rcnt increments.
  - At rcnt=N-1: clear full[rbank] and toggle rbank. If full of the other bank is already set on that edge, stay in BURST with rcnt=0 (back-to-back frames). Otherwise go to IDLE.
- Outputs are registered. out_en=1 exactly for the N cycles carrying a frame.
  - Output k of a frame carries the input sample with natural index bitrev(k).
  - out_start=1 with k=0. out_last=1 with k=N-1.
  - frame_count increments on the edge that registers out_last.
- Latency:
  - Last input sample of a frame captured at edge T.
  - First output (k=0) is valid after edge T+2: one edge for the IDLE→BURST decision, one for the registered RAM read.
  - With continuous input, out_en stays high continuously from the first frame onward.
- Simultaneous events:
  - The writer setting full[x] and the reader clearing full[y] on the same edge is legal.
  - x==y cannot occur unless overrun, which is blocked as above.
- No arithmetic: data passes through bit-exact. There is no saturation and no sign handling beyond storage.
- Reset mid-frame or mid-burst: everything is discarded immediately. out_en drops asynchronously to 0 and no partial burst is ever emitted.

Decomposition:
- Shared package fft_pkg holds:
  - N and LOG2N constants
  - WIDTH default
  - bitrev function on LOG2N bits
  - reader state enum (IDLE, BURST)
- One sub-module, fft_bitrev_bank: a simple dual-port RAM, depth 2N, data width 2*WIDTH.
  - Address is {bank, addr}.
  - Synchronous write and registered read.
  - Inferable as block RAM or LUTRAM.

Test Plan:
1. Single frame, in_real=n, in_imag=-n for n=0..15 in consecutive cycles → out_real sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with out_imag the negation of each. out_en is high for 16 contiguous cycles. The first output appears 2 edges after the last input. out_start is on the first output, out_last on the 16th, and frame_count=1 afterwards.
2. Cosine frame: x[n]=round(32768·cos(2πn/16)) in natural order, i.e. 32768, 30274, 23170, 12540, 0, -12540, ... → output order x[0], x[8], x[4], x[12], x[2], ... Feeding this into fft_16_top gives a peak only at bins 1 and 15.
3. Four back-to-back frames, continuous in_en, frame f carrying values 100f+n → out_en is continuously high for 64 cycles, each frame is correctly bit-reversed, and frame_count=4.
4. in_en toggled 1/0 every cycle for one frame → the single output burst is still 16 contiguous cycles, starting 2 edges after the 16th accepted sample. Data matches scenario 1.
5. Reset pulled low after 7 samples of frame 2, while frame 1 is mid-burst → out_en=0 immediately, with no further outputs. After reset release, a fresh full frame is emitted correctly and frame_count restarts from 0.
6. 15 samples, then in_en=0 for 40 cycles → no output. Supplying the 16th sample then produces the full burst.
